// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - parametrised GPIO port with atomic writes, input sync and edge interrupts
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             irq,
  inout  wire  [WIDTH-1:0] pins
);

  localparam logic [3:0] ADDR_OUT  = 4'd0;
  localparam logic [3:0] ADDR_DIR  = 4'd1;
  localparam logic [3:0] ADDR_IN   = 4'd2;
  localparam logic [3:0] ADDR_SET  = 4'd3;
  localparam logic [3:0] ADDR_CLR  = 4'd4;
  localparam logic [3:0] ADDR_TGL  = 4'd5;
  localparam logic [3:0] ADDR_RISE = 4'd6;
  localparam logic [3:0] ADDR_FALL = 4'd7;
  localparam logic [3:0] ADDR_PEND = 4'd8;

  logic [WIDTH-1:0] out_val;
  logic [WIDTH-1:0] dir_val;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;

  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] rd_next;

  // Pad per bit: combinational output with enable (maps onto an SB_IO with
  // non-registered output/enable and unregistered input). DIR clearing
  // asynchronously on reset releases the pins at once.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pins[i] = dir_val[i] ? out_val[i] : 1'bz;
  end

  assign in_val = sync[SYNC_STAGES-1];
  assign rise   = in_val & ~prev;
  assign fall   = ~in_val & prev;
  assign clr    = (we && addr == ADDR_PEND) ? wd : '0;

  // New events are OR-ed in after the clear so a set beats a same-cycle W1C.
  always_comb begin
    pend_next = (pend & ~clr) | (rise & rise_en) | (fall & fall_en);
  end

  // Bus write decode, including the atomic set/clear/toggle views of OUT.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      out_val <= '0;
      dir_val <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (we) begin
      case (addr)
        ADDR_OUT:  out_val <= wd;
        ADDR_DIR:  dir_val <= wd;
        ADDR_SET:  out_val <= out_val | wd;
        ADDR_CLR:  out_val <= out_val & ~wd;
        ADDR_TGL:  out_val <= out_val ^ wd;
        ADDR_RISE: rise_en <= wd;
        ADDR_FALL: fall_en <= wd;
        default:   ;
      endcase
    end
  end

  // Input synchroniser chain; prev follows the synchronised level for edge detect.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync <= '0;
      prev <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pins};
      prev <= in_val;
    end
  end

  // Sticky pending bits; irq is registered from the next pending value so it
  // rises on the same edge as the pending bit.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pend <= '0;
      irq  <= 1'b0;
    end else begin
      pend <= pend_next;
      irq  <= |pend_next;
    end
  end

  // Read mux over pre-write register values; write-only and unused addresses read 0.
  always_comb begin
    rd_next = '0;
    case (addr)
      ADDR_OUT:  rd_next = out_val;
      ADDR_DIR:  rd_next = dir_val;
      ADDR_IN:   rd_next = in_val;
      ADDR_RISE: rd_next = rise_en;
      ADDR_FALL: rd_next = fall_en;
      ADDR_PEND: rd_next = pend;
      default:   rd_next = '0;
    endcase
  end

  // Registered read data, held while re is low.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd <= '0;
    end else if (re) begin
      rd <= rd_next;
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - self-checking bench for gpio_port
module tb_gpio_port;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         resetq = 1'b0;
  logic [3:0]   addr = '0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [W-1:0] wd = '0;
  logic [W-1:0] rd;
  logic         irq;
  wire  [W-1:0] pins;

  logic [W-1:0] ext_oe = '1;
  logic [W-1:0] ext_val = 8'hA5;

  int n_checks = 0;
  int n_pass   = 0;

  gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .resetq(resetq), .addr(addr), .we(we), .re(re),
    .wd(wd), .rd(rd), .irq(irq), .pins(pins)
  );

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign pins[i] = ext_oe[i] ? ext_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: registers as plain variables, pin history as a queue
  // where samp[j] is the pin sample taken j edges ago.
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_pend, m_rd;
  logic         m_irq;
  logic [W-1:0] samp[$];

  always @(posedge clk or negedge resetq) begin
    logic [W-1:0] cur_in, cur_prev, ev, c;
    if (!resetq) begin
      m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_rd = '0; m_irq = 1'b0;
      samp = {};
      for (int j = 0; j <= S; j++) samp.push_back('0);
    end else begin
      cur_in   = samp[S-1];
      cur_prev = samp[S];
      if (re) begin
        case (addr)
          4'd0: m_rd = m_out;
          4'd1: m_rd = m_dir;
          4'd2: m_rd = cur_in;
          4'd6: m_rd = m_rise;
          4'd7: m_rd = m_fall;
          4'd8: m_rd = m_pend;
          default: m_rd = '0;
        endcase
      end
      ev = (cur_in & ~cur_prev & m_rise) | (~cur_in & cur_prev & m_fall);
      c  = (we && addr == 4'd8) ? wd : '0;
      m_pend = (m_pend & ~c) | ev;
      m_irq  = |m_pend;
      if (we) begin
        case (addr)
          4'd0: m_out = wd;
          4'd1: m_dir = wd;
          4'd3: m_out = m_out | wd;
          4'd4: m_out = m_out & ~wd;
          4'd5: m_out = m_out ^ wd;
          4'd6: m_rise = wd;
          4'd7: m_fall = wd;
          default: ;
        endcase
      end
      samp.push_front(pins);
      void'(samp.pop_back());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetq) begin
      check("cyc_rd", {8'h0, rd}, {8'h0, m_rd});
      check("cyc_irq", {15'h0, irq}, {15'h0, m_irq});
      check("cyc_pins", {8'h0, pins & m_dir}, {8'h0, m_out & m_dir});
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [W-1:0] v);
    @(negedge clk);
    re = 1'b1; addr = a;
    @(posedge clk);
    #1 re = 1'b0;
    v = rd;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;

    // Reset with pins pulled externally to A5.
    cycles(3);
    check("rst_rd", {8'h0, rd}, 16'h0);
    check("rst_irq", {15'h0, irq}, 16'h0);
    check("rst_pins", {8'h0, pins}, 16'h00A5);
    @(negedge clk) resetq = 1'b1;
    cycles(3);
    bus_read(4'd2, v); check("rst_in", {8'h0, v}, 16'h00A5);
    bus_read(4'd8, v); check("rst_pend", {8'h0, v}, 16'h0000);

    // Direction/output: low nibble driven by the port, high nibble external.
    ext_oe = 8'hF0;
    bus_write(4'd1, 8'h0F);
    bus_write(4'd0, 8'h3C);
    check("drv_lo", {12'h0, pins[3:0]}, 16'h000C);
    check("drv_hi", {12'h0, pins[7:4]}, 16'h000A);
    bus_read(4'd0, v); check("rd_out", {8'h0, v}, 16'h003C);
    cycles(2);
    bus_read(4'd2, v); check("rd_in", {8'h0, v}, 16'h00AC);

    // Atomic set/clear/toggle.
    bus_write(4'd3, 8'h81); bus_read(4'd0, v); check("set", {8'h0, v}, 16'h00BD);
    bus_write(4'd4, 8'h0C); bus_read(4'd0, v); check("clr", {8'h0, v}, 16'h00B1);
    bus_write(4'd5, 8'hFF); bus_read(4'd0, v); check("tgl", {8'h0, v}, 16'h004E);
    bus_read(4'd3, v); check("rd_set0", {8'h0, v}, 16'h0000);

    // Edge interrupts: pin0 low, pin1 high, all externally driven.
    bus_write(4'd1, 8'h00);
    ext_oe = 8'hFF; ext_val = 8'h02;
    cycles(4);
    bus_write(4'd8, 8'hFF);
    bus_write(4'd6, 8'h01);
    bus_write(4'd7, 8'h02);
    cycles(2);
    @(negedge clk) ext_val[0] = 1'b1;
    for (int k = 0; k < S; k++) begin
      @(posedge clk); #1 check("irq_early", {15'h0, irq}, 16'h0);
    end
    @(posedge clk); #1 check("irq_at_ks", {15'h0, irq}, 16'h1);
    bus_read(4'd8, v); check("pend_rise", {8'h0, v}, 16'h0001);
    @(negedge clk) ext_val[1] = 1'b0;
    cycles(4);
    bus_read(4'd8, v); check("pend_fall", {8'h0, v}, 16'h0003);
    @(negedge clk) ext_val[0] = 1'b0;
    cycles(4);
    bus_read(4'd8, v); check("pend_nochg", {8'h0, v}, 16'h0003);

    // W1C colliding with a new enabled rise on pin0.
    bus_write(4'd8, 8'hFF);
    @(negedge clk) ext_val[0] = 1'b1;
    cycles(4);
    bus_read(4'd8, v); check("pend_pre", {8'h0, v}, 16'h0001);
    @(negedge clk) ext_val[0] = 1'b0;
    cycles(4);
    @(negedge clk) ext_val[0] = 1'b1;
    @(posedge clk);
    repeat (S - 1) @(posedge clk);
    @(negedge clk); we = 1'b1; addr = 4'd8; wd = 8'h01;
    @(posedge clk); #1 we = 1'b0;
    check("coll_irq", {15'h0, irq}, 16'h1);
    bus_read(4'd8, v); check("coll_pend", {8'h0, v}, 16'h0001);
    bus_write(4'd8, 8'h01);
    check("w1c_irq", {15'h0, irq}, 16'h0);
    bus_read(4'd8, v); check("w1c_pend", {8'h0, v}, 16'h0000);

    // Async reset mid-operation with all pins driven by the port.
    bus_write(4'd6, 8'h00);
    bus_write(4'd7, 8'h00);
    bus_write(4'd0, 8'h00);
    ext_val = 8'h00;
    ext_oe = 8'h00;
    bus_write(4'd1, 8'hFF);
    cycles(4);
    bus_write(4'd8, 8'hFF);
    bus_write(4'd6, 8'h05);
    bus_write(4'd0, 8'h05);
    cycles(4);
    bus_read(4'd8, v); check("pend_05", {8'h0, v}, 16'h0005);
    check("irq_05", {15'h0, irq}, 16'h1);
    @(negedge clk);
    #1 resetq = 1'b0; ext_oe = 8'hFF; ext_val = 8'hFA;
    #1;
    check("ar_pins", {8'h0, pins}, 16'h00FA);
    check("ar_irq", {15'h0, irq}, 16'h0);
    check("ar_rd", {8'h0, rd}, 16'h0);
    @(posedge clk); #1 resetq = 1'b1;
    bus_read(4'd0, v); check("ar_out", {8'h0, v}, 16'h0);
    bus_read(4'd1, v); check("ar_dir", {8'h0, v}, 16'h0);
    bus_read(4'd6, v); check("ar_rise", {8'h0, v}, 16'h0);
    bus_read(4'd7, v); check("ar_fall", {8'h0, v}, 16'h0);
    bus_read(4'd8, v); check("ar_pend", {8'h0, v}, 16'h0);
    bus_read(4'd9, v); check("rd_unused", {8'h0, v}, 16'h0);

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
